// File: rtl/qfix_pkg.sv
// Shared definitions for the signed-magnitude fixed-point arithmetic blocks:
// default format, divider FSM encoding and sign/magnitude field helpers.
package qfix_pkg;

  localparam int QFIX_Q = 15;
  localparam int QFIX_N = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } qfix_state_t;

  // Sign of a product or quotient of two signed-magnitude operands.
  function automatic logic sm_result_sign(input logic sign_a, input logic sign_b);
    return sign_a ^ sign_b;
  endfunction

  // A zero magnitude is always reported as positive zero.
  function automatic logic sm_fix_sign(input logic sign, input logic mag_zero);
    return sign & ~mag_zero;
  endfunction

endpackage

// File: rtl/qdiv.sv
// Sequential signed-magnitude fixed-point divider: one quotient bit per clock
// using a restoring shift-subtract loop, handshaked by i_start / o_complete.
module qdiv
  import qfix_pkg::*;
#(
  parameter int Q = QFIX_Q,
  parameter int N = QFIX_N
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic         o_complete,
  output logic         o_busy,
  output logic         o_ovr,
  output logic         o_div_zero
);

  localparam int W  = N - 1 + Q;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  qfix_state_t    state;
  logic [W-1:0]   num;      // numerator bits shift out the top, quotient bits shift in
  logic [N-1:0]   rem;
  logic [N-2:0]   dvsr;
  logic           sign_q;
  logic           dz_q;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   rem_shift;
  logic           q_bit;
  logic [N-1:0]   rem_next;
  logic [W-1:0]   quo_next;
  logic           ovr_raw;
  logic [N-2:0]   final_mag;

  // NOTE: every always_comb output gets a default on every path, otherwise a
  // latch is inferred to hold the previous value.
  always_comb begin
    rem_shift = {rem[N-2:0], num[W-1]};
    q_bit     = (rem_shift >= {1'b0, dvsr});
    rem_next  = rem_shift;
    if (q_bit) begin
      rem_next = rem_shift - {1'b0, dvsr};
    end
    quo_next  = {num[W-2:0], q_bit};
    ovr_raw   = |quo_next[W-1:N-1];
    final_mag = ovr_raw ? '1 : quo_next[N-2:0];
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      num        <= '0;
      rem        <= '0;
      dvsr       <= '0;
      sign_q     <= 1'b0;
      dz_q       <= 1'b0;
      cnt        <= '0;
      o_quotient <= '0;
      o_complete <= 1'b0;
      o_busy     <= 1'b0;
      o_ovr      <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      o_complete <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (i_start) begin
            num        <= {i_dividend[N-2:0], {Q{1'b0}}};
            rem        <= '0;
            dvsr       <= i_divisor[N-2:0];
            sign_q     <= sm_result_sign(i_dividend[N-1], i_divisor[N-1]);
            dz_q       <= (i_divisor[N-2:0] == '0);
            cnt        <= '0;
            o_busy     <= (i_divisor[N-2:0] != '0);
            o_ovr      <= 1'b0;
            o_div_zero <= 1'b0;
            state      <= ST_CALC;
          end
        end

        ST_CALC: begin
          if (dz_q) begin
            // Zero divisor: no iterations, report saturated result on the next edge.
            o_quotient <= {sign_q, {(N-1){1'b1}}};
            o_ovr      <= 1'b1;
            o_div_zero <= 1'b1;
            o_complete <= 1'b1;
            dz_q       <= 1'b0;
            state      <= ST_DONE;
          end else begin
            num <= quo_next;
            rem <= rem_next;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              o_quotient <= {sm_fix_sign(sign_q, final_mag == '0), final_mag};
              o_ovr      <= ovr_raw;
              o_busy     <= 1'b0;
              o_complete <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv.sv
// Self-checking bench for qdiv: table-driven divisions plus hand-written
// sequences for start-during-CALC, back-to-back operation and mid-run reset.
module tb_qdiv;

  localparam int N = 32;
  localparam int Q = 15;
  localparam int W = N - 1 + Q;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] o_quotient;
  logic         o_complete;
  logic         o_busy;
  logic         o_ovr;
  logic         o_div_zero;

  int tests  = 0;
  int failed = 0;
  logic [N-1:0] prev_q;

  always #5 clk = ~clk;

  qdiv #(.Q(Q), .N(N)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_dividend (a),
    .i_divisor  (b),
    .o_quotient (o_quotient),
    .o_complete (o_complete),
    .o_busy     (o_busy),
    .o_ovr      (o_ovr),
    .o_div_zero (o_div_zero)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic         ovr;
    logic         dz;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_div(input logic [N-1:0] va, input logic [N-1:0] vb,
                         input logic [N-1:0] eq, input logic eovr, input logic edz,
                         input int elat, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~va;
    b     = '0;
    check({nm, " busy after accept"}, 64'(o_busy), 64'(!edz));
    check({nm, " ovr cleared"}, 64'(o_ovr), 64'(0));
    check({nm, " dz cleared"}, 64'(o_div_zero), 64'(0));
    check({nm, " quotient held"}, 64'(o_quotient), 64'(prev_q));
    n = 0;
    while (n < 100 && !o_complete) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, " latency"}, 64'(n), 64'(elat));
    check({nm, " quotient"}, 64'(o_quotient), 64'(eq));
    check({nm, " ovr"}, 64'(o_ovr), 64'(eovr));
    check({nm, " div_zero"}, 64'(o_div_zero), 64'(edz));
    check({nm, " busy at done"}, 64'(o_busy), 64'(0));
    @(posedge clk);
    #1;
    check({nm, " complete one cycle"}, 64'(o_complete), 64'(0));
    prev_q = eq;
  endtask

  initial begin
    int n;
    int n_done;
    int lat;

    vecs[0] = '{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0, W, "3/2"};
    vecs[1] = '{32'h8001_8000, 32'h0001_0000, 32'h8000_C000, 1'b0, 1'b0, W, "-3/2"};
    vecs[2] = '{32'h8000_0000, 32'h8000_8000, 32'h0000_0000, 1'b0, 1'b0, W, "-0/-1"};
    vecs[3] = '{32'h4000_0000, 32'h0000_4000, 32'h7FFF_FFFF, 1'b1, 1'b0, W, "ovr"};
    vecs[4] = '{32'h8000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, "div0"};
    vecs[5] = '{32'h8000_8000, 32'h8001_8000, 32'h0000_2AAA, 1'b0, 1'b0, W, "-1/-3"};
    vecs[6] = '{32'h0001_0000, 32'h8000_8000, 32'h8001_0000, 1'b0, 1'b0, W, "2/-1"};
    vecs[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, W, "max/lsb"};
    vecs[8] = '{32'h0000_3FFF, 32'h0000_8000, 32'h0000_3FFF, 1'b0, 1'b0, W, "x/1"};
    vecs[9] = '{32'h8000_0001, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, W, "trunc to 0"};

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    prev_q = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset quotient", 64'(o_quotient), 64'(0));
    check("reset complete", 64'(o_complete), 64'(0));
    check("reset busy", 64'(o_busy), 64'(0));
    check("reset ovr", 64'(o_ovr), 64'(0));
    check("reset div_zero", 64'(o_div_zero), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].ovr, vecs[i].dz, vecs[i].lat, vecs[i].name);
    end

    // Start pulses during CALC must be ignored.
    @(negedge clk);
    start = 1'b1;
    a     = 32'h0001_8000;
    b     = 32'h0001_0000;
    @(posedge clk);
    #1;
    a      = 32'h0001_0000;
    b      = 32'h0000_8000;
    n_done = 0;
    lat    = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = (i == 10 || i == 20 || i == 30);
      @(posedge clk);
      #1;
      if (o_complete) begin
        n_done++;
        lat = i;
      end
    end
    start = 1'b0;
    check("ignore start: completions", 64'(n_done), 64'(1));
    check("ignore start: latency", 64'(lat), 64'(W));
    check("ignore start: quotient", 64'(o_quotient), 64'h0000_C000);
    check("ignore start: busy", 64'(o_busy), 64'(0));

    // Back-to-back: i_start held through DONE accepts the next request at once.
    @(negedge clk);
    start = 1'b1;
    a     = 32'h0001_8000;
    b     = 32'h0001_0000;
    @(posedge clk);
    #1;
    n = 0;
    while (n < 100 && !o_complete) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b first latency", 64'(n), 64'(W));
    check("b2b first quotient", 64'(o_quotient), 64'h0000_C000);
    @(negedge clk);
    a = 32'h0000_8000;
    b = 32'h0001_8000;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (n < 100 && !o_complete);
    start = 1'b0;
    check("b2b second latency", 64'(n), 64'(W + 1));
    check("b2b second quotient", 64'(o_quotient), 64'h0000_2AAA);
    repeat (2) @(posedge clk);
    #1;
    check("b2b returns idle", 64'(o_busy), 64'(0));

    // Asynchronous reset in the middle of an iteration run.
    @(negedge clk);
    start = 1'b1;
    a     = 32'h8001_8000;
    b     = 32'h0001_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset quotient", 64'(o_quotient), 64'(0));
    check("mid reset busy", 64'(o_busy), 64'(0));
    check("mid reset complete", 64'(o_complete), 64'(0));
    check("mid reset ovr", 64'(o_ovr), 64'(0));
    n_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (o_complete) n_done++;
    end
    check("mid reset no completion", 64'(n_done), 64'(0));
    prev_q = '0;
    run_div(32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0, W, "after reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/qdiv.md
# qdiv

Sequential signed-magnitude fixed-point divider, the inverse of the fixed-point multiplier in the `pbit` arithmetic library.
- Operands and result use the same (N, Q) format: MSB is the sign; N-1 magnitude bits, of which Q are fractional.
- It computes one quotient bit per clock with a restoring shift-subtract loop, handshaked by start and complete.
- Datapath blocks use it for normalisation and ratio terms, where a combinational divide would not close timing.

## Interface
- `Q`, 15, number of fractional bits.
- `N`, 32, total word width including the sign bit.

- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `i_start`  in  1  request a division; sampled only when `o_busy`=0.
- `i_dividend`  in  N  signed-magnitude dividend; captured on the accepting edge.
- `i_divisor`  in  N  signed-magnitude divisor; captured on the accepting edge.
- `o_quotient`  out  N  signed-magnitude result; held until the next completion.
- `o_complete`  out  1  one-cycle pulse; `o_quotient` and the flags are valid from this cycle.
- `o_busy`  out  1  high while iterating.
- `o_ovr`  out  1  quotient magnitude did not fit in N-1 bits, or divide by zero.
- `o_div_zero`  out  1  divisor magnitude was zero.

## Operation
- **States:**
  - IDLE (after reset).
  - CALC.
  - DONE.
- **Accepting a request:** `i_start`=1 in IDLE or DONE is accepted at that edge and the FSM goes to CALC.
  - `i_start` during CALC is ignored; it is not queued.
- **Operand capture:**
  - Magnitudes are `|a|` = dividend[N-2:0] and `|b|` = divisor[N-2:0].
  - Sign = dividend[N-1] XOR divisor[N-1].
- **Numerator:** `|a|` << Q, width W = N-1+Q bits.
- **Iteration:** W iterations, MSB first, restoring.
  - The remainder register is N bits wide: rem = {rem, next numerator bit}.
  - If rem >= `|b|`: rem -= `|b|` and the quotient bit is 1; otherwise the quotient bit is 0.
- **Result:** the raw quotient is W bits.
  - Overflow when raw[W-1:N-1] != 0. On overflow the magnitude saturates to all ones and `o_ovr`=1.
  - Otherwise the magnitude is raw[N-2:0].
- **Divide by zero:** `|b|`=0 skips CALC and goes straight to DONE.
  - Magnitude is all ones, sign is the XOR of the input signs, and `o_ovr`=`o_div_zero`=1.
- **Zero result:** a zero result magnitude forces the sign bit to 0 (no negative zero). This matches the multiplier convention.
- **Remainder:** discarded; quotient bits are truncated, not rounded.

## Timing
- **Reset values:**
  - `o_quotient`=0.
  - `o_complete`=0.
  - `o_busy`=0.
  - `o_ovr`=0.
  - `o_div_zero`=0.
  - FSM in IDLE.
- **Accepting edge:** call it edge k.
  - `o_busy` rises after edge k.
  - The W iterations occur at edges k+1 … k+W.
- **Completion:** at edge k+W, `o_quotient`, `o_ovr` and `o_div_zero` are updated, `o_busy` falls, `o_complete` rises and the FSM enters DONE.
  - Latency is W cycles start-to-complete; 46 cycles at the defaults.
- **Divide by zero:** `o_complete` rises after edge k+1 and `o_busy` stays 0.
- **`o_complete`:** high for exactly one cycle.
  - DONE returns to IDLE on the next edge unless `i_start`=1 there.
  - `i_start` in DONE gives back-to-back operation, with no idle cycle required.
- **Flags:** `o_ovr` and `o_div_zero` hold with `o_quotient` until the next completion; they are cleared on acceptance of the next request.
- **Input stability:** operand changes after edge k have no effect.
- **Reset mid-CALC:** the operation is aborted immediately (asynchronous). All outputs go to reset values and no `o_complete` is produced.

## Structure
- **Shared package `qfix_pkg`:**
  - Default Q and N.
  - FSM state encoding (IDLE, CALC, DONE).
  - The signed-magnitude sign/magnitude field helpers shared with the multiplier.
- **Iteration counter:** width clog2(W+1), local to the block.
- **Sub-modules:** none; the compare-subtract step is one line of datapath and stays inline.

## Test plan
- 0x00018000 / 0x00010000 (3.0/2.0) -> `o_quotient`=0x0000C000, `o_complete` 46 cycles after the start edge, `o_ovr`=0.
- 0x80018000 / 0x00010000 -> 0x8000C000; 0x80000000 / 0x80008000 (-0/-1.0) -> 0x00000000 (sign cleared).
- 0x40000000 / 0x00004000 (32768/0.5) -> 0x7FFFFFFF, `o_ovr`=1, `o_div_zero`=0.
- 0x80008000 / 0x00000000 -> 0xFFFFFFFF, `o_ovr`=1, `o_div_zero`=1, `o_complete` one cycle after start.
- Start pulses during CALC are ignored (exactly one `o_complete` per accepted start); `i_start` held in DONE gives a second result after 46 more cycles.
- Assert `i_rst_n`=0 at iteration 20 -> all outputs are 0 immediately; no `o_complete`; a fresh start afterwards completes correctly.
